student_iic_init_seq: RTL and testbench



---
 rtl/student_iic_init_seq.sv | 218 +++++++++++++++++++++
 tb/tb_student_iic_init_seq.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/student_iic_init_seq.sv
// Table-driven I2C configuration sequencer: walks an external byte table, groups entries
// into write transactions for student_iic_master, and retries failed transactions.
module student_iic_init_seq #(
    parameter int N_ENTRIES      = 64,
    parameter int IDX_W          = $clog2(N_ENTRIES),
    parameter int MAX_RETRY      = 3,
    parameter int GAP_CYCLES     = 250,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [IDX_W-1:0] fail_idx_o,
    output logic [IDX_W-1:0] tbl_addr_o,
    input  logic [16:0]      tbl_data_i,
    output logic             iic_stb_o,
    output logic [7:0]       iic_a_o,
    output logic [7:0]       iic_d_o,
    input  logic             iic_done_i,
    input  logic             iic_err_i
);

    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int TMO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(N_ENTRIES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
    localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GAP_W-1:0]   GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        XFER,
        GAP,
        FIN
    } SeqState;

    SeqState state, stateNext;

    logic [IDX_W-1:0]   idx, idxNext;
    logic [IDX_W-1:0]   txnBase, txnBaseNext;
    logic [RETRY_W-1:0] retryCnt, retryCntNext;
    logic               lastR, lastRNext;
    logic               retryPend, retryPendNext;
    logic [TMO_W-1:0]   tmoCnt, tmoCntNext;
    logic [GAP_W-1:0]   gapCnt, gapCntNext;

    logic               busyNext;
    logic               doneNext;
    logic               errNext;
    logic [IDX_W-1:0]   failIdxNext;
    logic [IDX_W-1:0]   tblAddrNext;
    logic               stbNext;
    logic [7:0]         aNext;
    logic [7:0]         dNext;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext     = state;
        idxNext       = idx;
        txnBaseNext   = txnBase;
        retryCntNext  = retryCnt;
        lastRNext     = lastR;
        retryPendNext = retryPend;
        tmoCntNext    = tmoCnt;
        gapCntNext    = gapCnt;
        busyNext      = busy_o;
        doneNext      = 1'b0;
        errNext       = err_o;
        failIdxNext   = fail_idx_o;
        tblAddrNext   = tbl_addr_o;
        stbNext       = iic_stb_o;
        aNext         = iic_a_o;
        dNext         = iic_d_o;

        case (state)
            IDLE: begin
                if (start_i) begin
                    idxNext       = '0;
                    txnBaseNext   = '0;
                    retryCntNext  = '0;
                    retryPendNext = 1'b0;
                    errNext       = 1'b0;
                    busyNext      = 1'b1;
                    stateNext     = FETCH;
                end
            end

            FETCH: begin
                stateNext = LOAD;
            end

            // The final table entry always closes its transaction, so idx never runs past it.
            LOAD: begin
                aNext      = tbl_data_i[15:8];
                dNext      = tbl_data_i[7:0];
                lastRNext  = tbl_data_i[16] | (idx == LAST_IDX);
                tmoCntNext = '0;
                stbNext    = 1'b1;
                stateNext  = XFER;
            end

            // Error outranks success; a good done in the timeout cycle still counts as success.
            XFER: begin
                tmoCntNext = tmoCnt + 1'b1;
                if (iic_err_i) begin
                    stbNext       = 1'b0;
                    retryPendNext = 1'b1;
                    gapCntNext    = '0;
                    stateNext     = GAP;
                end else if (iic_done_i) begin
                    if (lastR) begin
                        stbNext    = 1'b0;
                        gapCntNext = '0;
                        stateNext  = GAP;
                    end else begin
                        idxNext   = idx + 1'b1;
                        stateNext = FETCH;
                    end
                end else if (tmoCnt == TMO_LAST) begin
                    stbNext       = 1'b0;
                    retryPendNext = 1'b1;
                    gapCntNext    = '0;
                    stateNext     = GAP;
                end
            end

            GAP: begin
                if (gapCnt != GAP_LAST) begin
                    gapCntNext = gapCnt + 1'b1;
                end else if (retryPend) begin
                    if (retryCnt < RETRY_MAX) begin
                        retryCntNext  = retryCnt + 1'b1;
                        retryPendNext = 1'b0;
                        idxNext       = txnBase;
                        stateNext     = FETCH;
                    end else begin
                        errNext     = 1'b1;
                        failIdxNext = txnBase;
                        stateNext   = FIN;
                    end
                end else if (idx == LAST_IDX) begin
                    stateNext = FIN;
                end else begin
                    idxNext      = idx + 1'b1;
                    txnBaseNext  = idx + 1'b1;
                    retryCntNext = '0;
                    stateNext    = FETCH;
                end
            end

            FIN: begin
                doneNext  = 1'b1;
                busyNext  = 1'b0;
                stateNext = IDLE;
            end

            default: begin
                stateNext = IDLE;
            end
        endcase

        // Present the new index during FETCH so the table answers in time for LOAD.
        if (stateNext == FETCH) begin
            tblAddrNext = idxNext;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            idx        <= '0;
            txnBase    <= '0;
            retryCnt   <= '0;
            lastR      <= 1'b0;
            retryPend  <= 1'b0;
            tmoCnt     <= '0;
            gapCnt     <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            fail_idx_o <= '0;
            tbl_addr_o <= '0;
            iic_stb_o  <= 1'b0;
            iic_a_o    <= '0;
            iic_d_o    <= '0;
        end else begin
            idx        <= idxNext;
            txnBase    <= txnBaseNext;
            retryCnt   <= retryCntNext;
            lastR      <= lastRNext;
            retryPend  <= retryPendNext;
            tmoCnt     <= tmoCntNext;
            gapCnt     <= gapCntNext;
            busy_o     <= busyNext;
            done_o     <= doneNext;
            err_o      <= errNext;
            fail_idx_o <= failIdxNext;
            tbl_addr_o <= tblAddrNext;
            iic_stb_o  <= stbNext;
            iic_a_o    <= aNext;
            iic_d_o    <= dNext;
        end
    end

endmodule

// File: tb/tb_student_iic_init_seq.sv
// Bench for student_iic_init_seq: a small I2C master stub and a one-cycle-latency table model
// driven by a table of scenarios, plus a mid-transfer reset sequence.
module tb_student_iic_init_seq;

    localparam int N_ENT    = 4;
    localparam int GAP_CYC  = 8;
    localparam int TMO_CYC  = 32;
    localparam int MAX_RTY  = 3;
    localparam int ADDR_LAT = 3;
    localparam int BYTE_LAT = 4;
    localparam int BUDGET   = 3000;
    localparam int N_VEC    = 5;

    logic        clk;
    logic        rst_ni;
    logic        start_i;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic [1:0]  fail_idx_o;
    logic [1:0]  tbl_addr_o;
    logic [16:0] tbl_data_i;
    logic        iic_stb_o;
    logic [7:0]  iic_a_o;
    logic [7:0]  iic_d_o;
    logic        iic_done_i;
    logic        iic_err_i;

    student_iic_init_seq #(
        .N_ENTRIES      (N_ENT),
        .IDX_W          (2),
        .MAX_RETRY      (MAX_RTY),
        .GAP_CYCLES     (GAP_CYC),
        .TIMEOUT_CYCLES (TMO_CYC)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .start_i    (start_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .fail_idx_o (fail_idx_o),
        .tbl_addr_o (tbl_addr_o),
        .tbl_data_i (tbl_data_i),
        .iic_stb_o  (iic_stb_o),
        .iic_a_o    (iic_a_o),
        .iic_d_o    (iic_d_o),
        .iic_done_i (iic_done_i),
        .iic_err_i  (iic_err_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0][16:0] tbl;
        logic             masterOn;
        logic [7:0]       nackAddr;
        logic             nackOn;
        logic [7:0]       nackByte;
        logic             pokeStart;
        logic [7:0]       expStarts;
        logic [7:0][1:0]  expStartIdx;
        logic [7:0]       expBytes;
        logic [7:0][7:0]  expStream;
        logic [7:0]       expGapLow;
        logic             expErr;
        logic [1:0]       expFailIdx;
        logic [15:0]      expHigh;
    } TestVec;

    TestVec      vecs [N_VEC];
    logic [16:0] tblMem [N_ENT];
    logic [16:0] romPipe;

    int total;
    int bad;

    logic       cfgMasterOn;
    logic       cfgNackOn;
    logic [7:0] cfgNackByte;
    int         cfgNackAddrUntil;

    int         stubAttempts;
    int         stubBytes;
    logic [7:0] byteLog [64];

    int         monRises;
    int         monFalls;
    int         monHigh;
    int         monDone;
    int         lowRun;
    logic       stbPrev;
    logic [1:0] riseIdx [8];
    logic [7:0] riseAddr [8];
    int         riseGap [8];

    // Synchronous table: data follows the address one clock later.
    initial begin
        tbl_data_i = '0;
        romPipe    = '0;
        forever begin
            @(negedge clk);
            tbl_data_i = romPipe;
            romPipe    = tblMem[tbl_addr_o];
        end
    end

    task automatic driveDone(input logic withErr);
        iic_done_i = 1'b1;
        iic_err_i  = withErr;
        @(negedge clk);
        iic_done_i = 1'b0;
        iic_err_i  = 1'b0;
    endtask

    // Master stub: one transaction per strobe rise, byte latched just before its done pulse.
    task automatic serveTransaction();
        logic       stop;
        logic [7:0] b;
        stop = 1'b0;
        repeat (ADDR_LAT) @(negedge clk);
        if (stubAttempts < cfgNackAddrUntil) begin
            stubAttempts++;
            driveDone(1'b1);
            stop = 1'b1;
        end else begin
            stubAttempts++;
        end
        for (int k = 0; k < 16 && !stop; k++) begin
            repeat (BYTE_LAT) @(negedge clk);
            b = iic_d_o;
            if (stubBytes < 64) byteLog[stubBytes] = b;
            stubBytes++;
            if (cfgNackOn && b == cfgNackByte) begin
                driveDone(1'b1);
                stop = 1'b1;
            end else begin
                driveDone(1'b0);
                if (!iic_stb_o) stop = 1'b1;
            end
        end
        for (int k = 0; k < 64 && iic_stb_o; k++) @(negedge clk);
    endtask

    initial begin
        iic_done_i   = 1'b0;
        iic_err_i    = 1'b0;
        stubAttempts = 0;
        stubBytes    = 0;
        forever begin
            @(negedge clk);
            if (cfgMasterOn && iic_stb_o) serveTransaction();
        end
    end

    task automatic tick();
        @(negedge clk);
        if (iic_stb_o) begin
            monHigh++;
            if (!stbPrev) begin
                if (monRises < 8) begin
                    riseIdx[monRises]  = tbl_addr_o;
                    riseAddr[monRises] = iic_a_o;
                    riseGap[monRises]  = lowRun;
                end
                monRises++;
            end
            lowRun = 0;
        end else begin
            lowRun++;
            if (stbPrev) monFalls++;
        end
        if (done_o) monDone++;
        stbPrev = iic_stb_o;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input int i);
        TestVec v;
        int     cyc;
        int     byteBase;
        v = vecs[i];
        for (int k = 0; k < N_ENT; k++) tblMem[k] = v.tbl[k];
        cfgMasterOn      = v.masterOn;
        cfgNackOn        = v.nackOn;
        cfgNackByte      = v.nackByte;
        cfgNackAddrUntil = stubAttempts + int'(v.nackAddr);
        byteBase = stubBytes;
        monRises = 0;
        monFalls = 0;
        monHigh  = 0;
        monDone  = 0;
        lowRun   = 0;

        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        checkOutput($sformatf("s%0d_busy_after_start", i), busy_o, 1);
        checkOutput($sformatf("s%0d_err_cleared", i), err_o, 0);

        cyc = 0;
        while (monDone == 0 && cyc < BUDGET) begin
            if (v.pokeStart && cyc == 20) start_i = 1'b1;
            tick();
            start_i = 1'b0;
            cyc++;
        end
        checkOutput($sformatf("s%0d_done_seen", i), (monDone > 0) ? 1 : 0, 1);
        checkOutput($sformatf("s%0d_busy_at_done", i), busy_o, 0);
        repeat (5) tick();
        checkOutput($sformatf("s%0d_done_pulses", i), monDone, 1);
        checkOutput($sformatf("s%0d_err", i), err_o, v.expErr);
        if (v.expErr) checkOutput($sformatf("s%0d_fail_idx", i), fail_idx_o, v.expFailIdx);

        checkOutput($sformatf("s%0d_starts", i), monRises, v.expStarts);
        checkOutput($sformatf("s%0d_stops", i), monFalls, v.expStarts);
        for (int k = 0; k < int'(v.expStarts) && k < 8; k++) begin
            checkOutput($sformatf("s%0d_start%0d_idx", i, k), riseIdx[k], v.expStartIdx[k]);
            checkOutput($sformatf("s%0d_start%0d_addr", i, k), riseAddr[k],
                        v.tbl[v.expStartIdx[k]][15:8]);
        end
        checkOutput($sformatf("s%0d_byte_count", i), stubBytes - byteBase, v.expBytes);
        for (int k = 0; k < int'(v.expBytes) && k < 8; k++) begin
            checkOutput($sformatf("s%0d_byte%0d", i, k), byteLog[byteBase + k], v.expStream[k]);
        end
        if (v.expGapLow != 0) checkOutput($sformatf("s%0d_gap_low", i), riseGap[1], v.expGapLow);
        if (v.expHigh != 0) checkOutput($sformatf("s%0d_stb_high", i), monHigh, v.expHigh);
    endtask

    initial begin
        int cyc;
        total       = 0;
        bad         = 0;
        rst_ni      = 1'b0;
        start_i     = 1'b0;
        cfgMasterOn = 1'b0;
        cfgNackOn   = 1'b0;
        cfgNackByte = 8'h00;
        cfgNackAddrUntil = 0;
        stbPrev     = 1'b0;
        monRises = 0; monFalls = 0; monHigh = 0; monDone = 0; lowRun = 0;
        for (int k = 0; k < N_ENT; k++) tblMem[k] = '0;

        // Stream and index fields list element 0 rightmost.
        vecs[0] = '0;
        vecs[0].tbl = {{1'b0, 8'h70, 8'h55}, {1'b0, 8'h70, 8'h0F},
                       {1'b0, 8'h70, 8'h00}, {1'b0, 8'h70, 8'h40}};
        vecs[0].masterOn  = 1'b1;
        vecs[0].expStarts = 8'd1;
        vecs[0].expBytes  = 8'd4;
        vecs[0].expStream = {32'h0, 8'h55, 8'h0F, 8'h00, 8'h40};

        vecs[1] = '0;
        vecs[1].tbl = {{1'b1, 8'h1A, 8'h44}, {1'b0, 8'h1A, 8'h33},
                       {1'b1, 8'h70, 8'h22}, {1'b0, 8'h70, 8'h11}};
        vecs[1].masterOn    = 1'b1;
        vecs[1].pokeStart   = 1'b1;
        vecs[1].expStarts   = 8'd2;
        vecs[1].expStartIdx = {12'h0, 2'd2, 2'd0};
        vecs[1].expBytes    = 8'd4;
        vecs[1].expStream   = {32'h0, 8'h44, 8'h33, 8'h22, 8'h11};
        vecs[1].expGapLow   = 8'(GAP_CYC + 2);

        vecs[2] = vecs[0];
        vecs[2].nackAddr  = 8'd1;
        vecs[2].expStarts = 8'd2;

        vecs[3] = vecs[1];
        vecs[3].pokeStart   = 1'b0;
        vecs[3].nackOn      = 1'b1;
        vecs[3].nackByte    = 8'h33;
        vecs[3].expStarts   = 8'd5;
        vecs[3].expStartIdx = {6'h0, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0};
        vecs[3].expBytes    = 8'd6;
        vecs[3].expStream   = {16'h0, 8'h33, 8'h33, 8'h33, 8'h33, 8'h22, 8'h11};
        vecs[3].expErr      = 1'b1;
        vecs[3].expFailIdx  = 2'd2;

        vecs[4] = vecs[0];
        vecs[4].masterOn   = 1'b0;
        vecs[4].expStarts  = 8'd4;
        vecs[4].expBytes   = 8'd0;
        vecs[4].expStream  = '0;
        vecs[4].expGapLow  = 8'(GAP_CYC + 2);
        vecs[4].expErr     = 1'b1;
        vecs[4].expFailIdx = 2'd0;
        vecs[4].expHigh    = 16'((MAX_RTY + 1) * TMO_CYC);

        repeat (3) tick();
        checkOutput("rst_busy", busy_o, 0);
        checkOutput("rst_done", done_o, 0);
        checkOutput("rst_err", err_o, 0);
        checkOutput("rst_fail_idx", fail_idx_o, 0);
        checkOutput("rst_tbl_addr", tbl_addr_o, 0);
        checkOutput("rst_stb", iic_stb_o, 0);
        checkOutput("rst_a", iic_a_o, 0);
        checkOutput("rst_d", iic_d_o, 0);
        rst_ni = 1'b1;
        repeat (2) tick();

        for (int i = 0; i < N_VEC; i++) begin
            $display("[TB] scenario %0d", i);
            applyStimulus(i);
        end

        $display("[TB] reset during transfer");
        for (int k = 0; k < N_ENT; k++) tblMem[k] = vecs[0].tbl[k];
        cfgMasterOn = 1'b0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        cyc = 0;
        while (!iic_stb_o && cyc < 20) begin
            tick();
            cyc++;
        end
        checkOutput("midrst_stb_reached", iic_stb_o, 1);
        rst_ni = 1'b0;
        tick();
        checkOutput("midrst_stb", iic_stb_o, 0);
        checkOutput("midrst_busy", busy_o, 0);
        rst_ni = 1'b1;
        tick();
        applyStimulus(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
